fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 111 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-granular arbiter sharing one FIFO write port among NREQ
// write-domain requesters; full back-pressure reaches only the granted requester.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                      wclk,
    input  logic                      wrstn,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    input  logic [NREQ-1:0]           req_last,
    output logic [NREQ-1:0]           req_ready,
    output logic [WIDTH-1:0]          fifo_wdata,
    output logic                      fifo_wen,
    input  logic                      fifo_full,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [GW-1:0]  rr_q, rr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [GW-1:0]  pick, idx;
    logic           any_vld;
    logic           accept;
    logic           last_hit;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        pick    = '0;
        idx     = '0;
        any_vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = GW'((int'(rr_q) + k) % NREQ);
            if (!any_vld && req_valid[idx]) begin
                any_vld = 1'b1;
                pick    = idx;
            end
        end
    end

    assign accept   = (state_q == GRANT) && req_valid[grant_q] && !fifo_full;
    assign last_hit = req_last[grant_q] || (int'(cnt_q) + 1 == MAX_BURST);

    always_comb begin
        fifo_wdata = '0;
        req_ready  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == GW'(i)) begin
                fifo_wdata   = req_data[i*WIDTH +: WIDTH];
                req_ready[i] = (state_q == GRANT) && !fifo_full;
            end
        end
    end

    assign fifo_wen = accept;
    assign busy     = (state_q == GRANT);
    assign grant_id = grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_vld) begin
                    state_d = GRANT;
                    grant_d = pick;
                    rr_d    = pick;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                // A stalled or idle granted requester keeps the port; no timeout.
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    if (last_hit) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= GW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: cycle-level behavioural model of the
// arbitration rules plus directed scenarios pinned with hand-computed values.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int MAXB  = 4;

    logic                  wclk = 1'b0;
    logic                  wrstn = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_last = '0;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      fifo_wdata;
    logic                  fifo_wen;
    logic                  fifo_full = 1'b0;
    logic [1:0]            grant_id;
    logic                  busy;

    fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAXB)) dut (
        .wclk       (wclk),
        .wrstn      (wrstn),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_wdata (fifo_wdata),
        .fifo_wen   (fifo_wen),
        .fifo_full  (fifo_full),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 wclk = ~wclk;

    int n_chk = 0;
    int n_err = 0;

    // Requester-side traffic state (owned by the stimulus process)
    logic [NREQ-1:0]  active = '0;
    logic [NREQ-1:0]  vld_en = '1;
    int               len_left[NREQ];
    int               seq[NREQ];
    int               used[NREQ];
    logic [WIDTH-1:0] rd_arr[NREQ];

    // Hand-computed expectations for the current cycle, -1 = don't care
    bit lit_en = 1'b1;
    int lit_b = 0, lit_g = 0, lit_w = 0, lit_d = -1, lit_r = 0;

    // Reference model state (owned by the compare process)
    bit         m_busy = 1'b0;
    logic [1:0] m_gid = '0;
    logic [1:0] m_rr = 2'(NREQ - 1);
    int         m_cnt = 0;
    int         acc_cnt[NREQ];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    always @(negedge wclk) begin
        logic [NREQ-1:0]  e_rdy;
        logic [WIDTH-1:0] e_wd;
        bit               e_wen;
        int               pick;
        if (!wrstn) begin
            m_busy = 1'b0;
            m_gid  = '0;
            m_rr   = 2'(NREQ - 1);
            m_cnt  = 0;
            e_rdy  = '0;
            e_wen  = 1'b0;
        end else begin
            e_wen = m_busy && req_valid[m_gid] && !fifo_full;
            e_rdy = (m_busy && !fifo_full) ? (4'b0001 << m_gid) : 4'b0000;
        end
        e_wd = rd_arr[m_gid];

        chk("busy", 32'(busy), 32'(m_busy));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("fifo_wen", 32'(fifo_wen), 32'(e_wen));
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("fifo_wdata", 32'(fifo_wdata), 32'(e_wd));
        chk("one_ready", 32'($countones(req_ready) <= 1), 32'd1);
        chk("wen_vs_full", 32'(fifo_wen && fifo_full), 32'd0);
        chk("wen_in_idle", 32'(fifo_wen && !busy), 32'd0);

        if (lit_en) begin
            if (lit_b >= 0) chk("lit_busy", 32'(busy), lit_b);
            if (lit_g >= 0) chk("lit_grant", 32'(grant_id), lit_g);
            if (lit_w >= 0) chk("lit_wen", 32'(fifo_wen), lit_w);
            if (lit_d >= 0) chk("lit_wdata", 32'(fifo_wdata), lit_d);
            if (lit_r >= 0) chk("lit_ready", 32'(req_ready), lit_r);
        end

        // Advance the model across the coming rising edge
        if (wrstn) begin
            if (!m_busy) begin
                pick = -1;
                for (int d = 1; d <= NREQ; d++) begin
                    if (pick < 0 && req_valid[2'(m_rr + 2'(d))]) pick = int'(2'(m_rr + 2'(d)));
                end
                if (pick >= 0) begin
                    m_busy = 1'b1;
                    m_gid  = 2'(pick);
                    m_rr   = 2'(pick);
                    m_cnt  = 0;
                end
            end else if (e_wen) begin
                acc_cnt[m_gid]++;
                m_cnt++;
                if (req_last[m_gid] || m_cnt == MAXB) m_busy = 1'b0;
            end
        end
    end

    task automatic drive();
        logic [NREQ-1:0] lastv;
        lastv = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (len_left[i] == 1) lastv |= (4'b0001 << i);
            rd_arr[i] = {3'(i), 5'(seq[i])};
        end
        req_valid = active & vld_en;
        req_last  = lastv;
        req_data  = {rd_arr[3], rd_arr[2], rd_arr[1], rd_arr[0]};
    endtask

    task automatic advance();
        for (int i = 0; i < NREQ; i++) begin
            if (used[i] != acc_cnt[i]) begin
                used[i] = acc_cnt[i];
                seq[i]++;
                len_left[i]--;
                if (len_left[i] <= 0) active &= ~(4'b0001 << i);
            end
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
        lit_en = 1'b0;
        advance();
        drive();
    endtask

    task automatic lit(input int b, input int g, input int w, input int d, input int r);
        lit_en = 1'b1;
        lit_b = b; lit_g = g; lit_w = w; lit_d = d; lit_r = r;
    endtask

    task automatic arm(input int i, input int n);
        active |= (4'b0001 << i);
        len_left[i] = n;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            len_left[i] = 0; seq[i] = 0; used[i] = 0; acc_cnt[i] = 0;
        end
        drive();
        repeat (3) @(posedge wclk);
        #1 wrstn = 1'b1;
        lit_en = 1'b0;

        // Single requester 2, three-beat burst
        step(); arm(2, 3); drive(); lit(0, 0, 0, -1, 0);
        for (int b = 0; b < 3; b++) begin
            step(); lit(1, 2, 1, 8'h40 + b, 4'b0100);
        end
        step(); lit(0, 2, 0, -1, 0);

        // Requesters 0 and 1 with one-beat bursts alternate
        for (int k = 0; k < 8; k++) begin
            step();
            for (int i = 0; i < 2; i++) if (!active[i]) arm(i, 1);
            drive();
            if (k % 2 == 0) lit(0, -1, 0, -1, 0);
            else lit(1, ((k - 1) / 2) % 2, 1, -1, 1 << (((k - 1) / 2) % 2));
        end

        // Cap at MAXB beats: requester 3 streams 10 beats, requester 1 interleaves
        step(); active = '0; arm(3, 10); arm(1, 2); drive();
        for (int k = 0; k < 16; k++) begin
            if (k > 0) step();
            case (k)
                0, 5, 8, 13: lit(0, -1, 0, -1, 0);
                1:           lit(1, 3, 1, 8'h60, 4'b1000);
                4:           lit(1, 3, 1, 8'h63, 4'b1000);
                6, 7:        lit(1, 1, 1, -1, 4'b0010);
                9:           lit(1, 3, 1, 8'h64, 4'b1000);
                12:          lit(1, 3, 1, 8'h67, 4'b1000);
                15:          lit(1, 3, 1, 8'h69, 4'b1000);
                default:     lit(1, 3, 1, -1, 4'b1000);
            endcase
        end

        // Full for 5 cycles mid-burst; last beat coincides with the cap
        step(); arm(2, 4); drive(); lit(0, -1, 0, -1, 0);
        step(); lit(1, 2, 1, 8'h43, 4'b0100);
        step(); lit(1, 2, 1, 8'h44, 4'b0100);
        for (int k = 0; k < 5; k++) begin
            step(); fifo_full = 1'b1; lit(1, 2, 0, -1, 0);
        end
        step(); fifo_full = 1'b0; lit(1, 2, 1, 8'h45, 4'b0100);
        step(); lit(1, 2, 1, 8'h46, 4'b0100);
        step(); lit(0, 2, 0, -1, 0);

        // Granted requester drops valid for 3 cycles
        step(); arm(0, 3); arm(1, 3); arm(2, 3); arm(3, 5); drive(); lit(0, -1, 0, -1, 0);
        step(); lit(1, 3, 1, 8'h6A, 4'b1000);
        for (int k = 0; k < 3; k++) begin
            step(); vld_en = 4'b0111; drive(); lit(1, 3, 0, -1, 4'b1000);
        end
        step(); vld_en = '1; drive(); lit(1, 3, 1, 8'h6B, 4'b1000);

        // Asynchronous reset mid-burst, then requester 0 wins
        step();
        #2 wrstn = 1'b0;
        lit(0, 0, 0, -1, 0);
        @(posedge wclk);
        #1 wrstn = 1'b1;
        lit_en = 1'b0;
        advance();
        for (int i = 0; i < NREQ; i++) if (!active[i]) arm(i, 1);
        drive();
        lit(0, 0, 0, -1, 0);
        step(); lit(1, 0, 1, -1, 4'b0001);

        // Randomized traffic with random back-pressure and valid gaps
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (!active[i] && $urandom_range(0, 3) == 0) arm(i, int'($urandom_range(1, 10)));
                if ($urandom_range(0, 9) == 0) vld_en &= ~(4'b0001 << i);
                else vld_en |= (4'b0001 << i);
            end
            fifo_full = ($urandom_range(0, 4) == 0);
            drive();
        end

        @(posedge wclk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
